// File: rtl/corescore_stream_arb.sv
// Packet-level round-robin arbiter sharing one 8-bit AXI-Stream sink between N byte sources.
// Optional stalled-owner watchdog is compiled in with `define CORESCORE_ARB_WATCHDOG_EN.
module corescore_stream_arb #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [8*N-1:0] i_tdata,
  input  logic [N-1:0]   i_tlast,
  input  logic [N-1:0]   i_tvalid,
  output logic [N-1:0]   o_tready,
  output logic [7:0]     o_tdata,
  output logic           o_tlast,
  output logic           o_tvalid,
  input  logic           i_tready,
  output logic [N-1:0]   o_grant,
  output logic           o_abort
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam logic [0:0]   ST_IDLE   = 1'b0;
  localparam logic [0:0]   ST_LOCK   = 1'b1;
  localparam logic [N-1:0] GRANT_ONE = N'(1);

  logic [0:0]    state_q, state_d;
  logic [LW-1:0] last_q, last_d;
  logic [LW-1:0] owner_q, owner_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          abort_q, abort_d;

  logic          lock;
  logic          owner_valid;
  logic          beat_end;
  logic          wd_fire;
  logic          sel_found;
  logic [LW-1:0] sel_idx;

  // A beat moves when o_tvalid and i_tready are both high on a rising edge; in LOCK
  // the owner's valid/ready/data/last pass straight through, so the owner's rules apply.
  assign lock        = (state_q == ST_LOCK);
  assign owner_valid = i_tvalid[owner_q];
  assign o_tvalid    = lock & owner_valid;
  assign o_tlast     = lock & i_tlast[owner_q];
  assign o_tdata     = lock ? i_tdata[{owner_q, 3'b000} +: 8] : 8'h00;
  assign o_tready    = lock ? (grant_q & {N{i_tready}}) : '0;
  assign o_grant     = grant_q;
  assign o_abort     = abort_q;
  assign beat_end    = o_tvalid & i_tready & o_tlast;

  // Search starts just after the last packet's owner and wraps through it.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int off = 1; off <= N; off++) begin
      if (!sel_found && i_tvalid[(int'(last_q) + off) % N]) begin
        sel_found = 1'b1;
        sel_idx   = LW'((int'(last_q) + off) % N);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    grant_d = grant_q;
    abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          state_d = ST_LOCK;
          owner_d = sel_idx;
          grant_d = GRANT_ONE << sel_idx;
        end
      end
      ST_LOCK: begin
        if (beat_end || wd_fire) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
          grant_d = '0;
          abort_d = wd_fire;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      last_q  <= LW'(N - 1);
      owner_q <= '0;
      grant_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      abort_q <= abort_d;
    end
  end

`ifdef CORESCORE_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_q, wd_d;

  // Fires on the cycle the idle count steps up to TIMEOUT-1, so o_abort shows on that edge.
  assign wd_fire = lock & ~owner_valid & (wd_q == CW'(TIMEOUT - 2));

  always_comb begin
    wd_d = wd_q + CW'(1);
    if (!lock || owner_valid || wd_fire) begin
      wd_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT < 2);
  assign wd_fire        = 1'b0;
`endif

endmodule

// File: tb/tb_corescore_stream_arb.sv
// Self-checking bench for corescore_stream_arb: directed scenarios plus randomized packet
// traffic scored against a packet-level round-robin model.
module tb_corescore_stream_arb;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam logic [N-1:0] ONE = N'(1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [8*N-1:0] s_tdata = '0;
  logic [N-1:0]   s_tlast = '0;
  logic [N-1:0]   s_tvalid = '0;
  logic [N-1:0]   s_tready;
  logic [7:0]     m_tdata;
  logic           m_tlast;
  logic           m_tvalid;
  logic           m_tready = 1'b0;
  logic [N-1:0]   grant;
  logic           abort;

  corescore_stream_arb #(.N(N), .TIMEOUT(TO)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_tdata  (s_tdata),
    .i_tlast  (s_tlast),
    .i_tvalid (s_tvalid),
    .o_tready (s_tready),
    .o_tdata  (m_tdata),
    .o_tlast  (m_tlast),
    .o_tvalid (m_tvalid),
    .i_tready (m_tready),
    .o_grant  (grant),
    .o_abort  (abort)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // per-source byte stores: {tlast, data}
  logic [8:0]  src_mem [N][64];
  int          head [N];
  int          tail [N];
  logic [N-1:0] at_start;
  logic [N-1:0] prev_gap;
  logic [N-1:0] accepted;

  // scoreboard: {src[3:0], tlast, data}
  logic [12:0] exp_q[$];
  int          mdl_last;
  logic        exp_grant_pend;
  logic [N-1:0] exp_grant_val;
  logic        last_beat_prev;
  int          rdy_mode;
  logic        gap_en;
  int          rdy_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_tvalid = '0;
    s_tlast = '0;
    s_tdata = '0;
    m_tready = 1'b0;
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    at_start = '1;
    prev_gap = '0;
    accepted = '0;
    exp_q.delete();
    mdl_last = N - 1;
    exp_grant_pend = 1'b0;
    last_beat_prev = 1'b0;
    gap_en = 1'b0;
    rdy_mode = 0;
    tick();
    tick();
    at_neg();
    chk("rst_grant", grant, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_abort", abort, 0);
    tick();
    rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic add_byte(input int src, input logic [7:0] data, input logic last);
    if (head[src] == tail[src]) begin
      head[src] = 0;
      tail[src] = 0;
    end
    src_mem[src][tail[src]] = {last, data};
    tail[src]++;
  endtask

  task automatic add_pkt(input int src, input int len);
    for (int b = 0; b < len; b++) add_byte(src, 8'($urandom_range(0, 255)), b == len - 1);
  endtask

  // Packet-level round robin over whatever is queued, all sources requesting from the start.
  task automatic build_expected();
    int rd [N];
    int s;
    logic [8:0] b;
    for (int k = 0; k < N; k++) rd[k] = head[k];
    while (1) begin
      s = -1;
      for (int off = 1; off <= N; off++) begin
        if (s < 0 && rd[(mdl_last + off) % N] < tail[(mdl_last + off) % N]) s = (mdl_last + off) % N;
      end
      if (s < 0) break;
      do begin
        b = src_mem[s][rd[s]];
        rd[s]++;
        exp_q.push_back({4'(s), b});
      end while (!b[8] && rd[s] < tail[s]);
      mdl_last = s;
    end
  endtask

  task automatic update_drive();
    logic gap;
    for (int k = 0; k < N; k++) begin
      if (head[k] < tail[k]) begin
        gap = gap_en && !at_start[k] && !prev_gap[k] && ($urandom_range(0, 2) == 0);
        prev_gap[k] = gap;
        s_tvalid[k] = !gap;
        s_tdata[8*k +: 8] = src_mem[k][head[k]][7:0];
        s_tlast[k] = src_mem[k][head[k]][8];
      end else begin
        prev_gap[k] = 1'b0;
        s_tvalid[k] = 1'b0;
        s_tdata[8*k +: 8] = 8'h00;
        s_tlast[k] = 1'b0;
      end
    end
    case (rdy_mode)
      1: m_tready = ($urandom_range(0, 3) != 0);
      2: m_tready = (rdy_cyc % 4 == 0) || (rdy_cyc % 4 == 3);
      default: m_tready = 1'b1;
    endcase
  endtask

  task automatic cycle_drive();
    tick();
    for (int k = 0; k < N; k++) begin
      if (accepted[k] && head[k] < tail[k]) begin
        at_start[k] = src_mem[k][head[k]][8];
        head[k]++;
      end
    end
    rdy_cyc++;
    update_drive();
  endtask

  // ---------------- scoreboard ----------------
  task automatic cycle_check();
    int gidx;
    at_neg();
    gidx = 0;
    for (int k = 0; k < N; k++) if (grant[k]) gidx = k;
    chk("grant_onehot0", 32'($onehot0(grant)), 1);
    if (exp_grant_pend) chk("grant_select", grant, exp_grant_val);
    if (last_beat_prev) chk("bubble_after_last", grant, 0);
    chk("tready_route", s_tready, grant & {N{m_tready}});
    if (grant == '0) chk("idle_tvalid", m_tvalid, 0);
    chk("abort_quiet", abort, 0);
    exp_grant_pend = 1'b0;
    last_beat_prev = 1'b0;
    if (grant == '0 && s_tvalid != '0 && exp_q.size() > 0) begin
      exp_grant_pend = 1'b1;
      exp_grant_val = ONE << exp_q[0][12:9];
    end
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) chk("beat_extra", exp_q.size(), 1);
      else chk("beat", {4'(gidx), m_tlast, m_tdata}, exp_q.pop_front());
      last_beat_prev = m_tlast;
    end
    accepted = s_tready & s_tvalid;
  endtask

  task automatic run_traffic(input int mode, input logic gaps, input int budget);
    int cyc;
    rdy_mode = mode;
    gap_en = gaps;
    rdy_cyc = 0;
    update_drive();
    cyc = 0;
    while (exp_q.size() > 0 && cyc < budget) begin
      cycle_check();
      cycle_drive();
      cyc++;
    end
    chk("drain_budget", exp_q.size(), 0);
    gap_en = 1'b0;
    rdy_mode = 0;
    repeat (2) begin
      cycle_check();
      cycle_drive();
    end
    if (exp_q.size() != 0) do_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();

    // "Hi\n" from source 0
    add_byte(0, 8'h48, 1'b0);
    add_byte(0, 8'h69, 1'b0);
    add_byte(0, 8'h0A, 1'b1);
    build_expected();
    run_traffic(0, 1'b0, 50);

    // sources 0 and 2, two 2-byte packets each
    do_reset();
    add_pkt(0, 2); add_pkt(0, 2);
    add_pkt(2, 2); add_pkt(2, 2);
    build_expected();
    run_traffic(0, 1'b0, 50);

    // source 1 owns a long packet while source 3 waits
    do_reset();
    add_pkt(1, 5);
    add_pkt(3, 2);
    build_expected();
    run_traffic(0, 1'b1, 80);

    // ready pattern 1,0,0,1 during a 4-byte packet
    add_pkt(2, 4);
    build_expected();
    run_traffic(2, 1'b0, 80);

    // lone requester, single-beat packets included
    add_pkt(3, 1); add_pkt(3, 3); add_pkt(3, 1);
    build_expected();
    run_traffic(1, 1'b0, 200);

    // all sources busy: grants rotate
    for (int k = 0; k < N; k++) begin
      add_pkt(k, 2);
      add_pkt(k, 1);
    end
    build_expected();
    run_traffic(0, 1'b0, 200);

    // randomized rounds
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < N; k++) begin
        int npk;
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) add_pkt(k, $urandom_range(1, 4));
      end
      build_expected();
      run_traffic(1, 1'b1, 3000);
    end

    // stalled owner: source 0 sends one byte without tlast, source 1 waits
    do_reset();
    s_tvalid = 4'b0011;
    s_tdata = {8'h00, 8'h00, 8'h66, 8'h55};
    s_tlast = 4'b0010;
    m_tready = 1'b1;
    tick();
    at_neg();
    chk("wd_first_grant", grant, 4'b0001);
    chk("wd_first_data", m_tdata, 8'h55);
    tick();
    s_tvalid[0] = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      at_neg();
      chk("wd_abort_low", abort, 0);
      chk("wd_hold", grant, 4'b0001);
      tick();
    end
`ifdef CORESCORE_ARB_WATCHDOG_EN
    at_neg();
    chk("wd_abort_pulse", abort, 1);
    chk("wd_abort_idle", grant, 0);
    tick();
    at_neg();
    chk("wd_abort_end", abort, 0);
    chk("wd_next_grant", grant, 4'b0010);
    chk("wd_next_data", m_tdata, 8'h66);
`else
    at_neg();
    chk("wd_off_abort", abort, 0);
    chk("wd_off_hold", grant, 4'b0001);
    tick();
    at_neg();
    chk("wd_off_abort2", abort, 0);
    chk("wd_off_hold2", grant, 4'b0001);
`endif

    // reset during byte 2 of a source-3 packet; source 0 then wins
    do_reset();
    s_tvalid[3] = 1'b1;
    s_tdata[31:24] = 8'hA0;
    m_tready = 1'b1;
    tick();
    at_neg();
    chk("rstmid_grant", grant, 4'b1000);
    chk("rstmid_b0", m_tdata, 8'hA0);
    tick();
    s_tdata[31:24] = 8'hA1;
    s_tvalid[0] = 1'b1;
    s_tdata[7:0] = 8'hB0;
    s_tlast[0] = 1'b1;
    rst = 1'b1;
    at_neg();
    chk("rstmid_b1", m_tdata, 8'hA1);
    tick();
    rst = 1'b0;
    at_neg();
    chk("rstmid_grant0", grant, 0);
    chk("rstmid_tvalid0", m_tvalid, 0);
    chk("rstmid_tready0", s_tready, 0);
    chk("rstmid_tdata0", m_tdata, 0);
    chk("rstmid_tlast0", m_tlast, 0);
    chk("rstmid_abort0", abort, 0);
    tick();
    at_neg();
    chk("rstmid_src0_wins", grant, 4'b0001);
    chk("rstmid_src0_data", m_tdata, 8'hB0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
